// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. The in-order pipeline writeback has
// priority; multi-cycle results that lose arbitration are parked in a small
// side FIFO. The FIFO drains on idle pipeline slots, or through a one-cycle
// forced stall once its head has waited MAX_WAIT cycles.
module wb_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_wb_en,
  input  logic                       pipe_memtoreg,
  input  logic [ADDR_W-1:0]          pipe_rd,
  input  logic [DATA_W-1:0]          pipe_mem_data,
  input  logic [DATA_W-1:0]          pipe_alu_data,
  input  logic                       mc_valid,
  input  logic [ADDR_W-1:0]          mc_rd,
  input  logic [DATA_W-1:0]          mc_data,
  output logic                       mc_ready,
  output logic                       pipe_stall,
  output logic                       rf_we,
  output logic [ADDR_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic [$clog2(DEPTH):0]     buf_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          fifo [DEPTH];
  logic [PW-1:0]   rptr, wptr;
  logic [CW-1:0]   used;      // occupied slots, including killed entries
  logic [WW-1:0]   wait_cnt, wait_nxt;
  logic            drain;

  logic   empty, full, head_valid, pipe_wr, mc_acc, mc_real;
  logic   g_drain, g_pipe, g_head, g_byp, pop, push;
  entry_t head;

  // Arbitration: forced drain > pipeline > FIFO head > empty-FIFO bypass.
  // rst gates the request side so nothing is granted while reset is held.
  always_comb begin
    empty      = (used == '0);
    full       = (used == CW'(DEPTH));
    head       = fifo[rptr];
    head_valid = !empty && head.valid;
    pipe_wr    = !rst && pipe_wb_en && (pipe_rd != '0);
    mc_ready   = !rst && !full;
    mc_acc     = mc_valid && mc_ready;
    mc_real    = mc_acc && (mc_rd != '0);
    g_drain    = drain && head_valid;
    g_pipe     = !g_drain && pipe_wr;
    g_head     = !g_drain && !pipe_wr && !empty;
    g_byp      = !g_drain && !pipe_wr && empty && mc_real;
    pop        = g_drain || g_head;
    push       = mc_real && !g_byp;
    pipe_stall = g_drain;
  end

  // Write-port mux; a killed head is popped with the port left idle.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (g_drain || (g_head && head.valid)) begin
      rf_we    = 1'b1;
      rf_waddr = head.rd;
      rf_wdata = head.data;
    end else if (g_pipe) begin
      rf_we    = 1'b1;
      rf_waddr = pipe_rd;
      rf_wdata = pipe_memtoreg ? pipe_mem_data : pipe_alu_data;
    end else if (g_byp) begin
      rf_we    = 1'b1;
      rf_waddr = mc_rd;
      rf_wdata = mc_data;
    end
  end

  // Live-entry count and head wait counter (saturating, reset on pop/no head).
  always_comb begin
    buf_count = '0;
    for (int i = 0; i < DEPTH; i++)
      buf_count = buf_count + CW'(fifo[i].valid);
    if (pop || !head_valid)
      wait_nxt = '0;
    else if (wait_cnt == WW'(MAX_WAIT))
      wait_nxt = wait_cnt;
    else
      wait_nxt = wait_cnt + WW'(1);
  end

  // FIFO storage, pointers, WAW kill and drain flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
      rptr     <= '0;
      wptr     <= '0;
      used     <= '0;
      wait_cnt <= '0;
      drain    <= 1'b0;
    end else begin
      // A granted pipeline write is younger than anything buffered for the same rd.
      if (g_pipe)
        for (int i = 0; i < DEPTH; i++)
          if (fifo[i].rd == pipe_rd) fifo[i].valid <= 1'b0;
      if (pop) begin
        fifo[rptr].valid <= 1'b0;
        rptr             <= rptr + PW'(1);
      end
      if (push) begin
        fifo[wptr].valid <= !(g_pipe && (mc_rd == pipe_rd));
        fifo[wptr].rd    <= mc_rd;
        fifo[wptr].data  <= mc_data;
        wptr             <= wptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   used <= used + CW'(1);
        2'b01:   used <= used - CW'(1);
        default: used <= used;
      endcase
      wait_cnt <= wait_nxt;
      drain    <= (wait_nxt == WW'(MAX_WAIT));
    end
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback path (MEM/WB register outputs) and a multi-cycle unit (mul/div) that completes out of band. Pipeline writes have priority. Multi-cycle results that lose arbitration are parked in a small FIFO. The FIFO drains on idle pipeline write slots, or by forcing a one-cycle pipeline stall when an entry has waited too long. The block sits between the MEM/WB register, the multi-cycle unit, the hazard unit and the register file.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width
DEPTH, 2, side-FIFO entries (power of 2, >=2)
MAX_WAIT, 4, cycles a non-empty FIFO head may be denied before a forced drain (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
pipe_wb_en  in  1  RegWrite bit from MEM/WB
pipe_memtoreg  in  1  MemtoReg bit from MEM/WB: 1 selects pipe_mem_data
pipe_rd  in  ADDR_W  destination register from MEM/WB
pipe_mem_data  in  DATA_W  load data from MEM/WB
pipe_alu_data  in  DATA_W  ALU result from MEM/WB
mc_valid  in  1  multi-cycle result valid
mc_rd  in  ADDR_W  multi-cycle destination register
mc_data  in  DATA_W  multi-cycle result
mc_ready  out  1  arbiter accepts mc result this cycle (= !full)
pipe_stall  out  1  to hazard unit: hold all stages incl. MEM/WB this cycle
rf_we  out  1  register-file write enable
rf_waddr  out  ADDR_W  register-file write address
rf_wdata  out  DATA_W  register-file write data
buf_count  out  clog2(DEPTH)+1  occupied FIFO entries (valid entries only)

Behaviour:
- State: FIFO entries {valid, rd, data}, read/write pointers, wait counter (0..MAX_WAIT), drain flag. All are cleared asynchronously by rst.
- While rst=1: rf_we=0, mc_ready=0, pipe_stall=0, buf_count=0. After rst deasserts: FIFO empty, counter 0.
- Outputs rf_*, pipe_stall and mc_ready are combinational from current state and inputs; the write takes effect at the next edge.
- pipe_wr = pipe_wb_en && pipe_rd!=0. A write to r0 is never issued.
- mc accept = mc_valid && mc_ready. If mc_rd==0, the result is accepted and discarded.
- Grant priority each cycle, first match wins:
  1. drain=1 and head valid: write head, pop, pipe_stall=1. The pipeline write is not issued and is retried next cycle with held inputs.
  2. pipe_wr: write pipeline data. Data = pipe_memtoreg ? pipe_mem_data : pipe_alu_data.
  3. Head valid: write head, pop.
  4. FIFO empty and accepted mc with mc_rd!=0: bypass write of mc, no push.
  5. Otherwise rf_we=0.
- Push: an accepted mc result with mc_rd!=0 that is not bypassed is pushed at the edge. Push and pop in the same cycle are legal; a push into a full FIFO is impossible because mc_ready=0.
- Invalidated FIFO entries are popped without a write, at one per cycle, consuming a grant-3 slot with rf_we=0.
- WAW kill: when a pipeline write to X is granted, every FIFO entry with rd==X, plus any same-cycle pushed mc result with rd X, is marked invalid. Invalid entries are popped without writing. The pipeline write is younger and wins.
- Wait counter: increments when the head is valid but not popped, saturating at MAX_WAIT. It clears on pop or when the FIFO is empty. When the counter equals MAX_WAIT, drain is set for the next cycle. Drain clears after the forced pop, so pipe_stall lasts exactly one cycle per forced drain.
- Order: FIFO entries retire strictly in arrival order.
- Reset mid-operation discards all buffered entries; no write is issued.

Test Plan:
- Idle pipe, mc_valid=1 rd=7 data=0x1234 -> same cycle rf_we=1 waddr=7 wdata=0x1234, buf_count stays 0.
- pipe_wb_en=1 rd=3 memtoreg=1 mem=0xAA alu=0xBB, plus mc rd=9 data=0x55 -> cycle0 writes r3=0xAA and pushes (buf_count=1). Next idle cycle writes r9=0x55, buf_count=0.
- Pipe writes every cycle, one mc entry buffered, MAX_WAIT=4 -> after 4 denied cycles pipe_stall=1 for exactly 1 cycle with rf_waddr=mc rd. The held pipeline write completes the following cycle.
- Buffer r5, then pipeline writes r5=0x77 -> the buffered entry is killed, r5 is never overwritten by mc data, buf_count returns to 0.
- Fill FIFO (DEPTH=2) under continuous pipe writes -> mc_ready=0. pipe_wb_en=0 / mc_rd=0 / pipe_rd=0 cases -> no write to r0; buffered entries drain in order.
- Assert rst with 2 entries buffered and drain pending -> immediately rf_we=0, pipe_stall=0, mc_ready=0. After release, buf_count=0 and no stale write occurs.
